inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction fetch stage: the producer of the 4-bit opcode consumed by the control decoder.
//  Holds a loadable program memory, a PC, and an IF/ID output register.
//  Issues one instruction per cycle with a valid flag, and supports stall, redirect (flush) and HALT.
//  inst[15:12] drives the decoder's inst input; downstream gates wen with inst_valid.
// PARAMETERS
//  ADDR_W   8     PC / program-memory address width; depth = 2**ADDR_W
//  INST_W   16    instruction width; opcode = inst[INST_W-1:INST_W-4]
//  HALT_OP  4'hF  opcode that stops fetching
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous reset, active-low
//  load_en      in   1       program-memory write strobe
//  load_addr    in   ADDR_W  program-memory write address
//  load_data    in   INST_W  program-memory write data
//  run          in   1       start pulse: pc<=0, go FETCH
//  stall        in   1       hold IF/ID register and PC
//  redirect     in   1       flush and load PC from redirect_pc
//  redirect_pc  in   ADDR_W  redirect target
//  inst         out  INST_W  IF/ID instruction
//  pc_out       out  ADDR_W  address of inst
//  inst_valid   out  1       inst is a real instruction
//  halted       out  1       high in HALT state
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, pc=0, inst=0, pc_out=0, inst_valid=0, halted=0.
//    Program memory is not reset. Reset mid-run aborts immediately with no partial issue.
//  - Memory write is synchronous. It takes effect only in IDLE or HALT; load_en in FETCH is ignored.
//  - Read of mem[pc] is combinational and registered into inst: 1-cycle fetch latency.
//  - FSM states: IDLE, FETCH, HALT. Priority within FETCH: redirect > stall > normal.
//    IDLE:  inst_valid=0; run=1 -> pc<=0, FETCH.
//    FETCH normal:   inst<=mem[pc]; pc_out<=pc; inst_valid<=1; pc<=pc+1, wrapping 2**ADDR_W-1 -> 0.
//    FETCH stall:    inst, pc_out, inst_valid and pc all hold.
//    FETCH redirect: pc<=redirect_pc; inst<=0; inst_valid<=0 (one bubble). Overrides stall.
//    FETCH, fetched opcode==HALT_OP (not stalled, not redirected): the HALT word issues
//      with inst_valid=1; pc does not increment; next state=HALT.
//    HALT: halted=1; inst_valid<=0 on the first HALT cycle, regardless of stall; pc frozen;
//      stall/redirect ignored; run=1 -> pc<=0, halted<=0, FETCH.
//  - run while in FETCH is ignored. Redirect in IDLE/HALT is ignored.
//  - Redirect on the cycle a HALT word would be fetched: the word is discarded and no halt occurs.
// TESTING
//  1 Reset: drop rst_n mid-FETCH -> outputs are 0 and state is IDLE with no clock edge needed.
//  2 Load mem[0..3]=0x0123,0x1456,0x2789,0xF000; pulse run -> inst is 0x0123, 0x1456, 0x2789, 0xF000
//    on consecutive cycles with pc_out 0..3 and inst_valid=1; then inst_valid=0 and halted=1;
//    pc stays 3.
//  3 Stall for 3 cycles while inst=0x1456 -> inst, pc_out=1 and inst_valid hold; fetch then
//    resumes with 0x2789.
//  4 Assert redirect=1 and stall=1 together with redirect_pc=0x10 -> one bubble (inst_valid=0);
//    next inst=mem[0x10] with pc_out=0x10.
//  5 Wrap: redirect to 0xFF with no HALT there -> pc_out goes 0xFF then 0x00.
//  6 load_en during FETCH -> memory unchanged. Pulse run in HALT -> refetch from pc 0 and halted=0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: loadable program memory, PC and IF/ID register.
// Issues one instruction per cycle with stall, redirect (flush) and HALT support.
module inst_fetch #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INST_W  = 16,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [INST_W-1:0] load_data,
  input  logic              run,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc_out,
  output logic              inst_valid,
  output logic              halted
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   pc_nx;
  logic [ADDR_W-1:0]   pc_out_nx;
  logic [INST_W-1:0]   inst_nx;
  logic                inst_valid_nx;
  logic                halted_nx;
  logic                mem_we_c;
  logic [INST_W-1:0]   rd_word_c;
  logic                is_halt_c;

  logic [INST_W-1:0]   mem [DEPTH];

  // Program memory: synchronous write, combinational read at pc
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[load_addr] <= load_data;
    end
  end

  assign rd_word_c = mem[pc];
  assign is_halt_c = (rd_word_c[INST_W-1 -: 4] == HALT_OP);

  // State, PC and IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= '0;
      inst       <= '0;
      pc_out     <= '0;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      inst       <= inst_nx;
      pc_out     <= pc_out_nx;
      inst_valid <= inst_valid_nx;
      halted     <= halted_nx;
    end
  end

  // Next-state and next-register values; redirect beats stall inside FETCH
  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    inst_nx       = inst;
    pc_out_nx     = pc_out;
    inst_valid_nx = inst_valid;
    halted_nx     = halted;
    mem_we_c      = 1'b0;

    case (state)
      IDLE: begin
        mem_we_c      = load_en;
        inst_valid_nx = 1'b0;
        halted_nx     = 1'b0;
        if (run) begin
          pc_nx    = '0;
          state_nx = FETCH;
        end
      end

      FETCH: begin
        if (redirect) begin
          pc_nx         = redirect_pc;
          inst_nx       = '0;
          inst_valid_nx = 1'b0;
        end else if (!stall) begin
          inst_nx       = rd_word_c;
          pc_out_nx     = pc;
          inst_valid_nx = 1'b1;
          if (is_halt_c) begin
            // HALT word issues but pc stays on it
            state_nx  = HALT;
            halted_nx = 1'b1;
          end else begin
            pc_nx = pc + ADDR_W'(1);
          end
        end
      end

      HALT: begin
        mem_we_c      = load_en;
        inst_valid_nx = 1'b0;
        halted_nx     = 1'b1;
        if (run) begin
          pc_nx     = '0;
          halted_nx = 1'b0;
          state_nx  = FETCH;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a behavioural model predicts each cycle's
// outputs into a queue, and a negedge monitor pops and compares.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic        run;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [15:0] inst;
  logic [7:0]  pc_out;
  logic        inst_valid;
  logic        halted;

  inst_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .run         (run),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .pc_out      (pc_out),
    .inst_valid  (inst_valid),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] inst;
    logic [7:0]  pc;
    logic        v;
    logic        h;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: program array, program counter, and a run mode
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic [15:0] m_mem [256];
  int          m_mode;
  int          m_pc;
  logic [15:0] m_inst;
  logic [7:0]  m_pcout;
  logic        m_valid;
  logic        m_halted;

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_pc     = 0;
    m_inst   = '0;
    m_pcout  = '0;
    m_valid  = 1'b0;
    m_halted = 1'b0;
  endtask

  // Apply one rising edge to the model using the inputs currently driven
  task automatic model_edge();
    logic [15:0] w;
    if (!rst_n) begin
      model_reset();
    end else if (m_mode == M_RUN) begin
      if (redirect) begin
        m_pc    = int'(redirect_pc);
        m_inst  = '0;
        m_valid = 1'b0;
      end else if (!stall) begin
        w       = m_mem[m_pc];
        m_inst  = w;
        m_pcout = 8'(m_pc);
        m_valid = 1'b1;
        if (w[15:12] == 4'hF) begin
          m_mode   = M_HALT;
          m_halted = 1'b1;
        end else begin
          m_pc = (m_pc + 1) % 256;
        end
      end
    end else begin
      if (load_en) m_mem[load_addr] = load_data;
      m_valid = 1'b0;
      if (run) begin
        m_pc     = 0;
        m_halted = 1'b0;
        m_mode   = M_RUN;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.inst = m_inst;
    e.pc   = m_pcout;
    e.v    = m_valid;
    e.h    = m_halted;
    exp_q.push_back(e);
  endtask

  // One cycle: model the edge just taken, queue its outputs, then drive next inputs
  task automatic cyc(input logic l, input logic [7:0] la, input logic [15:0] ld,
                     input logic r, input logic st, input logic rd, input logic [7:0] rpc);
    @(posedge clk);
    #1;
    model_edge();
    push_exp();
    load_en     = l;
    load_addr   = la;
    load_data   = ld;
    run         = r;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Async reset between edges: outputs must clear before the next clock edge
  task automatic do_reset();
    @(posedge clk);
    #1;
    model_edge();
    #1;
    rst_n       = 1'b0;
    load_en     = 1'b0;
    run         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    model_reset();
    push_exp();
    idle(1);
    rst_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs with the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks += 4;
      if (inst !== e.inst) begin
        n_fail++;
        $display("FAIL inst t=%0t got=%h want=%h", $time, inst, e.inst);
      end
      if (pc_out !== e.pc) begin
        n_fail++;
        $display("FAIL pc_out t=%0t got=%h want=%h", $time, pc_out, e.pc);
      end
      if (inst_valid !== e.v) begin
        n_fail++;
        $display("FAIL inst_valid t=%0t got=%b want=%b", $time, inst_valid, e.v);
      end
      if (halted !== e.h) begin
        n_fail++;
        $display("FAIL halted t=%0t got=%b want=%b", $time, halted, e.h);
      end
    end
  end

  initial begin
    logic [15:0] w;
    int          budget;
    rst_n       = 1'b0;
    load_en     = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    run         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = '0;

    idle(2);
    rst_n = 1'b1;

    // Fill the whole program memory with non-HALT words
    for (int a = 0; a < 256; a++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'hE;
      cyc(1'b1, 8'(a), w, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    cyc(1'b1, 8'h00, 16'h0123, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 8'h01, 16'h1456, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 8'h02, 16'h2789, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 8'h03, 16'hF000, 1'b0, 1'b0, 1'b0, 8'h00);

    // Straight run into HALT
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(7);

    // Restart from HALT, stall three cycles while 0x1456 is held
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
    idle(4);

    // Restart, then redirect+stall to 0x10, load_en ignored in FETCH, redirect to 0xFF to wrap
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 8'h02, 16'hAAAA, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h10);
    idle(3);
    cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'hFF);
    idle(3);
    // Reset mid-FETCH
    do_reset();
    idle(2);

    // Memory still intact after reset: run to HALT again, 0x2789 proves the ignored load
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(7);

    // Redirect on the cycle the HALT word would be fetched
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(3);
    cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h40);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cyc(($urandom_range(0, 3) == 0), 8'($urandom), 16'($urandom),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0), 8'($urandom));
      end
    end
    idle(2);

    budget = 10;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
